// File: rtl/pcie_fc_credit_gate.sv
// ---------------------------------------------------------------------------
// pcie_fc_credit_gate
//
// Transmit-side flow-control credit tracker for the datalink layer. For every
// virtual channel and every credit type (P, NP, CPL) it keeps the advertised
// credit limit (from InitFC/UpdateFC DLLPs), the credits consumed by launched
// TLPs, and an "infinite" flag per header/data field. Each TLP launch is gated
// by a ready/valid handshake that is only granted when enough credits remain.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   vc_init_i         per-VC level: 0 = FC_INIT/inactive, 1 = FC initialised
//   upd_*             one-cycle received FC DLLP (init/update, VC, type, fields)
//   req_valid_i       TLP launch request, held until accepted
//   req_vc_i/type_i   request VC and credit type
//   req_data_cred_i   data credits required (0 = no payload)
//   req_ready_o       credits sufficient; transfer on valid & ready
//   credits_avail_o   bit [3*vc+type]: >=1 hdr and >=MPS data credits left
//   fc_err_o          one-cycle pulse after an illegal UpdateFC
// ---------------------------------------------------------------------------
module pcie_fc_credit_gate #(
  parameter int VC_COUNT         = 1,
  parameter int VC_SEL_WIDTH     = 3,
  parameter int HDR_FC_WIDTH     = 8,
  parameter int DATA_FC_WIDTH    = 12,
  parameter int MAX_PAYLOAD_SIZE = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [VC_COUNT-1:0]       vc_init_i,
  input  logic                      upd_vld_i,
  input  logic                      upd_init_i,
  input  logic [VC_SEL_WIDTH-1:0]   upd_vc_i,
  input  logic [1:0]                upd_type_i,
  input  logic [HDR_FC_WIDTH-1:0]   upd_hdr_i,
  input  logic [DATA_FC_WIDTH-1:0]  upd_data_i,
  input  logic                      req_valid_i,
  input  logic [VC_SEL_WIDTH-1:0]   req_vc_i,
  input  logic [1:0]                req_type_i,
  input  logic [DATA_FC_WIDTH-1:0]  req_data_cred_i,
  output logic                      req_ready_o,
  output logic [3*VC_COUNT-1:0]     credits_avail_o,
  output logic                      fc_err_o
);

  localparam int MPS_CREDITS = MAX_PAYLOAD_SIZE / 16;
  localparam logic [HDR_FC_WIDTH-1:0]  HDR_HALF  = {1'b1, {(HDR_FC_WIDTH-1){1'b0}}};
  localparam logic [DATA_FC_WIDTH-1:0] DATA_HALF = {1'b1, {(DATA_FC_WIDTH-1){1'b0}}};
  localparam logic [DATA_FC_WIDTH-1:0] MPS_DW    = DATA_FC_WIDTH'(MPS_CREDITS);

  // Modulo-2^N window test: "used" stays within half the counter space of
  // "lim". This is both the sufficiency check and the UpdateFC legality check.
  function automatic logic hdr_fits(input logic [HDR_FC_WIDTH-1:0] lim,
                                    input logic [HDR_FC_WIDTH-1:0] used);
    logic [HDR_FC_WIDTH-1:0] diff;
    diff = lim - used;
    return (diff <= HDR_HALF);
  endfunction

  function automatic logic data_fits(input logic [DATA_FC_WIDTH-1:0] lim,
                                     input logic [DATA_FC_WIDTH-1:0] used);
    logic [DATA_FC_WIDTH-1:0] diff;
    diff = lim - used;
    return (diff <= DATA_HALF);
  endfunction

  logic [HDR_FC_WIDTH-1:0]  lim_hdr_q  [VC_COUNT][3];
  logic [HDR_FC_WIDTH-1:0]  lim_hdr_d  [VC_COUNT][3];
  logic [DATA_FC_WIDTH-1:0] lim_data_q [VC_COUNT][3];
  logic [DATA_FC_WIDTH-1:0] lim_data_d [VC_COUNT][3];
  logic [HDR_FC_WIDTH-1:0]  cons_hdr_q  [VC_COUNT][3];
  logic [HDR_FC_WIDTH-1:0]  cons_hdr_d  [VC_COUNT][3];
  logic [DATA_FC_WIDTH-1:0] cons_data_q [VC_COUNT][3];
  logic [DATA_FC_WIDTH-1:0] cons_data_d [VC_COUNT][3];
  logic                     inf_hdr_q  [VC_COUNT][3];
  logic                     inf_hdr_d  [VC_COUNT][3];
  logic                     inf_data_q [VC_COUNT][3];
  logic                     inf_data_d [VC_COUNT][3];

  logic [VC_COUNT-1:0]   vc_init_q;
  logic [VC_COUNT-1:0]   vc_act;
  logic                  fc_err_q, fc_err_d;
  logic [3*VC_COUNT-1:0] avail_q, avail_d;
  logic                  req_ready;
  logic                  req_fire;

  // A VC is active only once the init level has been seen for a full cycle;
  // the rising cycle itself is a freeze cycle, and a falling level gates
  // requests immediately.
  assign vc_act   = vc_init_q & vc_init_i;
  assign req_fire = req_valid_i & req_ready;

  // Request sufficiency: purely from registered state and request inputs,
  // never from upd_* in the same cycle.
  always_comb begin
    logic                     sel_hit;
    logic [HDR_FC_WIDTH-1:0]  sel_lim_hdr, sel_cons_hdr;
    logic [DATA_FC_WIDTH-1:0] sel_lim_data, sel_cons_data;
    logic                     sel_inf_hdr, sel_inf_data;
    logic                     hdr_ok, data_ok;
    sel_hit       = 1'b0;
    sel_lim_hdr   = '0;
    sel_cons_hdr  = '0;
    sel_lim_data  = '0;
    sel_cons_data = '0;
    sel_inf_hdr   = 1'b0;
    sel_inf_data  = 1'b0;
    for (int v = 0; v < VC_COUNT; v++) begin
      for (int t = 0; t < 3; t++) begin
        if (vc_act[v] && (req_vc_i == VC_SEL_WIDTH'(v)) && (req_type_i == 2'(t))) begin
          sel_hit       = 1'b1;
          sel_lim_hdr   = lim_hdr_q[v][t];
          sel_cons_hdr  = cons_hdr_q[v][t];
          sel_lim_data  = lim_data_q[v][t];
          sel_cons_data = cons_data_q[v][t];
          sel_inf_hdr   = inf_hdr_q[v][t];
          sel_inf_data  = inf_data_q[v][t];
        end
      end
    end
    hdr_ok    = sel_inf_hdr | hdr_fits(sel_lim_hdr, sel_cons_hdr + HDR_FC_WIDTH'(1));
    data_ok   = sel_inf_data | (req_data_cred_i == '0) |
                data_fits(sel_lim_data, sel_cons_data + req_data_cred_i);
    req_ready = req_valid_i & sel_hit & hdr_ok & data_ok;
  end

  // Next-state for limits, consumed counters and infinite flags.
  always_comb begin
    logic upd_hit, req_hit;
    lim_hdr_d   = lim_hdr_q;
    lim_data_d  = lim_data_q;
    cons_hdr_d  = cons_hdr_q;
    cons_data_d = cons_data_q;
    inf_hdr_d   = inf_hdr_q;
    inf_data_d  = inf_data_q;
    fc_err_d    = 1'b0;
    upd_hit     = 1'b0;
    req_hit     = 1'b0;
    for (int v = 0; v < VC_COUNT; v++) begin
      for (int t = 0; t < 3; t++) begin
        upd_hit = upd_vld_i && (upd_vc_i == VC_SEL_WIDTH'(v)) && (upd_type_i == 2'(t));
        req_hit = req_fire && (req_vc_i == VC_SEL_WIDTH'(v)) && (req_type_i == 2'(t));
        if (vc_init_q[v] && !vc_init_i[v]) begin
          // Link dropped: wipe this VC so a later re-init starts clean.
          lim_hdr_d[v][t]   = '0;
          lim_data_d[v][t]  = '0;
          cons_hdr_d[v][t]  = '0;
          cons_data_d[v][t] = '0;
          inf_hdr_d[v][t]   = 1'b0;
          inf_data_d[v][t]  = 1'b0;
        end else if (!vc_init_i[v]) begin
          // FC_INIT: only InitFC is accepted; a zero field means infinite.
          if (upd_hit && upd_init_i) begin
            lim_hdr_d[v][t]  = upd_hdr_i;
            lim_data_d[v][t] = upd_data_i;
            inf_hdr_d[v][t]  = (upd_hdr_i == '0);
            inf_data_d[v][t] = (upd_data_i == '0);
          end
        end else if (vc_init_q[v]) begin
          if (upd_hit && !upd_init_i) begin
            if (!inf_hdr_q[v][t]) begin
              lim_hdr_d[v][t] = upd_hdr_i;
              if (!hdr_fits(upd_hdr_i, cons_hdr_q[v][t])) fc_err_d = 1'b1;
            end
            if (!inf_data_q[v][t]) begin
              lim_data_d[v][t] = upd_data_i;
              if (!data_fits(upd_data_i, cons_data_q[v][t])) fc_err_d = 1'b1;
            end
          end
          // Consumed counters advance even for infinite fields.
          if (req_hit) begin
            cons_hdr_d[v][t]  = cons_hdr_q[v][t] + HDR_FC_WIDTH'(1);
            cons_data_d[v][t] = cons_data_q[v][t] + req_data_cred_i;
          end
        end
      end
    end
  end

  // Availability flags, registered from current counters.
  always_comb begin
    avail_d = '0;
    for (int v = 0; v < VC_COUNT; v++) begin
      for (int t = 0; t < 3; t++) begin
        avail_d[3*v+t] = vc_act[v] &
          (inf_hdr_q[v][t]  | hdr_fits(lim_hdr_q[v][t], cons_hdr_q[v][t] + HDR_FC_WIDTH'(1))) &
          (inf_data_q[v][t] | data_fits(lim_data_q[v][t], cons_data_q[v][t] + MPS_DW));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vc_init_q <= '0;
      fc_err_q  <= 1'b0;
      avail_q   <= '0;
      for (int v = 0; v < VC_COUNT; v++) begin
        for (int t = 0; t < 3; t++) begin
          lim_hdr_q[v][t]   <= '0;
          lim_data_q[v][t]  <= '0;
          cons_hdr_q[v][t]  <= '0;
          cons_data_q[v][t] <= '0;
          inf_hdr_q[v][t]   <= 1'b0;
          inf_data_q[v][t]  <= 1'b0;
        end
      end
    end else begin
      vc_init_q   <= vc_init_i;
      fc_err_q    <= fc_err_d;
      avail_q     <= avail_d;
      lim_hdr_q   <= lim_hdr_d;
      lim_data_q  <= lim_data_d;
      cons_hdr_q  <= cons_hdr_d;
      cons_data_q <= cons_data_d;
      inf_hdr_q   <= inf_hdr_d;
      inf_data_q  <= inf_data_d;
    end
  end

  assign req_ready_o     = req_ready;
  assign credits_avail_o = avail_q;
  assign fc_err_o        = fc_err_q;

endmodule

// File: tb/tb_pcie_fc_credit_gate.sv
// ---------------------------------------------------------------------------
// Directed bench for pcie_fc_credit_gate with four virtual channels.
// Inputs change 1 time unit after the rising edge; outputs are sampled a
// further time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_pcie_fc_credit_gate;

  localparam int VCN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  vc_init;
  logic        upd_vld, upd_init;
  logic [2:0]  upd_vc;
  logic [1:0]  upd_type;
  logic [7:0]  upd_hdr;
  logic [11:0] upd_data;
  logic        req_valid;
  logic [2:0]  req_vc;
  logic [1:0]  req_type;
  logic [11:0] req_data;
  logic        req_ready;
  logic [11:0] avail;
  logic        fc_err;

  int total = 0;
  int bad   = 0;

  pcie_fc_credit_gate #(
    .VC_COUNT(VCN), .VC_SEL_WIDTH(3), .HDR_FC_WIDTH(8),
    .DATA_FC_WIDTH(12), .MAX_PAYLOAD_SIZE(1024)
  ) dut (
    .clk_i(clk), .rst_i(rst), .vc_init_i(vc_init),
    .upd_vld_i(upd_vld), .upd_init_i(upd_init), .upd_vc_i(upd_vc),
    .upd_type_i(upd_type), .upd_hdr_i(upd_hdr), .upd_data_i(upd_data),
    .req_valid_i(req_valid), .req_vc_i(req_vc), .req_type_i(req_type),
    .req_data_cred_i(req_data), .req_ready_o(req_ready),
    .credits_avail_o(avail), .fc_err_o(fc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one FC DLLP for one cycle.
  task automatic upd(input logic init, input logic [2:0] vc, input logic [1:0] ty,
                     input logic [7:0] h, input logic [11:0] d);
    upd_vld = 1'b1; upd_init = init; upd_vc = vc; upd_type = ty;
    upd_hdr = h; upd_data = d;
    tick();
    upd_vld = 1'b0;
  endtask

  // Present one request for one cycle and check ready before the edge.
  task automatic req(input logic [2:0] vc, input logic [1:0] ty, input logic [11:0] d,
                     input logic exp, input string tag);
    req_valid = 1'b1; req_vc = vc; req_type = ty; req_data = d;
    #1;
    chk(tag, 32'(req_ready), 32'(exp));
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    int nr;
    rst = 1'b1; vc_init = 4'b0000;
    upd_vld = 1'b0; upd_init = 1'b0; upd_vc = '0; upd_type = '0; upd_hdr = '0; upd_data = '0;
    req_valid = 1'b0; req_vc = '0; req_type = '0; req_data = '0;
    tick(); tick();
    chk("reset ready", 32'(req_ready), 0);
    chk("reset avail", 32'(avail), 0);
    chk("reset err", 32'(fc_err), 0);
    rst = 1'b0;
    tick();

    // InitFC while every VC is in FC_INIT.
    upd(1'b1, 3'd0, 2'd0, 8'd4, 12'd32);
    upd(1'b1, 3'd0, 2'd1, 8'd0, 12'd0);
    upd(1'b1, 3'd0, 2'd2, 8'h80, 12'd0);
    upd(1'b1, 3'd2, 2'd0, 8'd10, 12'd100);
    upd(1'b1, 3'd3, 2'd0, 8'd0, 12'h7F8);
    upd(1'b0, 3'd2, 2'd0, 8'd200, 12'd0);   // UpdateFC while inactive: dropped
    chk("inactive update err", 32'(fc_err), 0);
    req(3'd0, 2'd0, 12'd8, 1'b0, "inactive req");

    // Activation cycle is a freeze cycle.
    vc_init = 4'b1101;
    req(3'd0, 2'd0, 12'd8, 1'b0, "activation cycle req");
    tick();
    chk("avail after activate", 32'(avail), 32'h246);
    upd(1'b1, 3'd0, 2'd0, 8'd100, 12'd100); // InitFC while active: ignored

    // Basic P credit exhaustion and replenish.
    for (int i = 0; i < 4; i++) req(3'd0, 2'd0, 12'd8, 1'b1, $sformatf("t1 req%0d", i));
    req(3'd0, 2'd0, 12'd8, 1'b0, "t1 fifth blocked");
    upd(1'b0, 3'd0, 2'd0, 8'd5, 12'd40);
    chk("t1 update err", 32'(fc_err), 0);
    req(3'd0, 2'd0, 12'd8, 1'b1, "t1 fifth after update");

    // Legality boundary and error pulse.
    upd(1'b0, 3'd0, 2'd0, 8'd10, 12'd40);
    for (int i = 0; i < 5; i++) req(3'd0, 2'd0, 12'd0, 1'b1, $sformatf("t5 req%0d", i));
    upd(1'b0, 3'd0, 2'd0, 8'd138, 12'd40);
    chk("t5 diff128 no err", 32'(fc_err), 0);
    upd(1'b0, 3'd0, 2'd0, 8'd139, 12'd40);
    chk("t5 diff129 err", 32'(fc_err), 1);
    tick();
    chk("t5 err one cycle", 32'(fc_err), 0);
    // Same-edge UpdateFC (limit 12) and consume (10 -> 11).
    upd_vld = 1'b1; upd_init = 1'b0; upd_vc = 3'd0; upd_type = 2'd0;
    upd_hdr = 8'd12; upd_data = 12'd40;
    req(3'd0, 2'd0, 12'd0, 1'b1, "t5 combo ready");
    upd_vld = 1'b0;
    chk("t5 combo err", 32'(fc_err), 0);
    req(3'd0, 2'd0, 12'd0, 1'b1, "t5 after combo");
    req(3'd0, 2'd0, 12'd0, 1'b0, "t5 combo blocked");

    // Infinite NP credits.
    nr = 0;
    req_valid = 1'b1; req_vc = 3'd0; req_type = 2'd1; req_data = 12'd5;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (req_ready !== 1'b1) nr++;
      tick();
    end
    req_valid = 1'b0;
    chk("t2 infinite not-ready count", 32'(nr), 0);
    upd(1'b0, 3'd0, 2'd1, 8'd3, 12'd0);
    chk("t2 infinite update err", 32'(fc_err), 0);
    req(3'd0, 2'd1, 12'd5, 1'b1, "t2 still ready");

    // Header wrap on CPL.
    nr = 0;
    req_valid = 1'b1; req_vc = 3'd0; req_type = 2'd2; req_data = 12'd3;
    for (int i = 0; i < 128; i++) begin
      #1;
      if (req_ready !== 1'b1) nr++;
      tick();
    end
    req_valid = 1'b0;
    chk("t3 first 128", 32'(nr), 0);
    req(3'd0, 2'd2, 12'd3, 1'b0, "t3 blocked at 0x80");
    upd(1'b0, 3'd0, 2'd2, 8'hFE, 12'd0);
    nr = 0;
    req_valid = 1'b1;
    for (int i = 0; i < 126; i++) begin
      #1;
      if (req_ready !== 1'b1) nr++;
      tick();
    end
    req_valid = 1'b0;
    chk("t3 next 126", 32'(nr), 0);
    req(3'd0, 2'd2, 12'd3, 1'b0, "t3 blocked at 0xFE");
    upd(1'b0, 3'd0, 2'd2, 8'h02, 12'd0);
    chk("t3 wrap update err", 32'(fc_err), 0);
    for (int i = 0; i < 4; i++) req(3'd0, 2'd2, 12'd3, 1'b1, $sformatf("t3 wrap req%0d", i));
    req(3'd0, 2'd2, 12'd3, 1'b0, "t3 wrap fifth blocked");

    // Data wrap on VC3 P (header infinite).
    req(3'd3, 2'd0, 12'h7F8, 1'b1, "t3d fill");
    req(3'd3, 2'd0, 12'd1, 1'b0, "t3d one over");
    upd(1'b0, 3'd3, 2'd0, 8'd0, 12'hFF8);
    chk("t3d diff2048 no err", 32'(fc_err), 0);
    req(3'd3, 2'd0, 12'h800, 1'b1, "t3d to 0xFF8");
    upd(1'b0, 3'd3, 2'd0, 8'd0, 12'h008);
    req(3'd3, 2'd0, 12'd16, 1'b1, "t3d wrap 16");
    req(3'd3, 2'd0, 12'd1, 1'b0, "t3d wrap blocked");
    req(3'd3, 2'd0, 12'd0, 1'b1, "t3d zero data");
    tick();
    chk("avail after wraps", 32'(avail), 32'h042);

    // Illegal indices and inactive VC.
    req(3'd1, 2'd0, 12'd0, 1'b0, "t4 inactive vc1");
    req(3'd0, 2'd3, 12'd0, 1'b0, "t4 type3");
    req(3'd5, 2'd0, 12'd0, 1'b0, "t4 vc out of range");

    // VC2: limit 10 (earlier inactive UpdateFC of 200 must not have landed).
    nr = 0;
    req_valid = 1'b1; req_vc = 3'd2; req_type = 2'd0; req_data = 12'd1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (req_ready !== 1'b1) nr++;
      tick();
    end
    chk("t4 vc2 ten", 32'(nr), 0);
    #1;
    chk("t4 vc2 eleventh", 32'(req_ready), 0);
    vc_init = 4'b1001;                      // drop VC2 with request pending
    tick();
    #1;
    chk("t4 after drop", 32'(req_ready), 0);
    req_valid = 1'b0;
    req(3'd0, 2'd1, 12'd5, 1'b1, "t4 vc0 unaffected");
    vc_init = 4'b1101;
    tick();
    req(3'd2, 2'd0, 12'd0, 1'b0, "t4 limits cleared");
    vc_init = 4'b1001;
    tick();
    upd(1'b1, 3'd2, 2'd0, 8'd2, 12'd20);
    vc_init = 4'b1101;
    tick();
    req(3'd2, 2'd0, 12'd10, 1'b1, "t4 reinit req0");
    req(3'd2, 2'd0, 12'd10, 1'b1, "t4 reinit req1");
    req(3'd2, 2'd0, 12'd10, 1'b0, "t4 reinit blocked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
